// File: rtl/dift_tag_init_engine_pkg.sv
// Shared DIFT types and constants for the tag init engine.
package pkg_dift;

   localparam int TAG_BITS_NUM = 4;

   typedef logic [TAG_BITS_NUM-1:0] tag_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      WR_REQ  = 3'd3,
      WR_WAIT = 3'd4,
      DONE    = 3'd5
   } dift_init_state_e;

   localparam tag_t TAG_ALL_TAINTED = '1;
   localparam tag_t TAG_ALL_CLEAN   = '0;

endpackage

// File: rtl/dift_tag_init_engine.sv
// TCDM read-modify-write engine that rewrites the tag bits of a word range, keeping data intact.
// Define DIFT_TAG_INIT_ERR_EN to make response errors (r_opc) abort the walk and raise err_o.
module dift_tag_init_engine
   import pkg_dift::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int TAG_BITS_NUM = pkg_dift::TAG_BITS_NUM
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       start_i,
   input  logic                       abort_i,
   input  logic [ADDR_WIDTH-1:0]      base_addr_i,
   input  logic [ADDR_WIDTH-1:0]      end_addr_i,
   input  logic [TAG_BITS_NUM-1:0]    tag_val_i,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       err_o,
   output logic                       tcdm_req_o,
   output logic [ADDR_WIDTH-1:0]      tcdm_add_o,
   output logic                       tcdm_wen_o,
   output logic [3:0]                 tcdm_be_o,
   output logic [32+TAG_BITS_NUM-1:0] tcdm_wdata_o,
   input  logic                       tcdm_gnt_i,
   input  logic                       tcdm_r_valid_i,
   input  logic [32+TAG_BITS_NUM-1:0] tcdm_r_rdata_i,
   input  logic                       tcdm_r_opc_i
);

   localparam int IW = ADDR_WIDTH - 2;
   localparam int DW = 32 + TAG_BITS_NUM;

   dift_init_state_e        state_q, state_d;
   logic [IW-1:0]           cur_q, cur_d;
   logic [IW-1:0]           end_q, end_d;
   logic [TAG_BITS_NUM-1:0] tag_q, tag_d;
   logic                    abort_q, abort_d;
   logic                    req_q, req_d;
   logic                    wen_q, wen_d;
   logic [ADDR_WIDTH-1:0]   add_q, add_d;
   logic [DW-1:0]           wdata_q, wdata_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;

   logic [IW-1:0]           base_idx_s;
   logic [IW-1:0]           end_idx_s;
   logic [IW-1:0]           nxt_idx_s;
   logic                    abort_any_s;
   logic                    resp_err_s;
   logic                    unused_s;

   assign base_idx_s  = base_addr_i[ADDR_WIDTH-1:2];
   assign end_idx_s   = end_addr_i[ADDR_WIDTH-1:2];
   assign nxt_idx_s   = cur_q + {{(IW-1){1'b0}}, 1'b1};
   assign abort_any_s = abort_q | abort_i;

`ifdef DIFT_TAG_INIT_ERR_EN
   assign resp_err_s = tcdm_r_opc_i;
`else
   assign resp_err_s = 1'b0;
`endif

   // Incoming tags and low address bits are never consumed; the walk works on word indices.
   assign unused_s = ^{tcdm_r_rdata_i[DW-1:32], base_addr_i[1:0], end_addr_i[1:0], tcdm_r_opc_i};

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      end_d   = end_q;
      tag_d   = tag_q;
      abort_d = abort_q;
      req_d   = req_q;
      wen_d   = wen_q;
      add_d   = add_q;
      wdata_d = wdata_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               busy_d  = 1'b1;
               err_d   = 1'b0;
               abort_d = 1'b0;
               tag_d   = tag_val_i;
               cur_d   = base_idx_s;
               end_d   = end_idx_s;
               if (base_idx_s < end_idx_s) begin
                  state_d = RD_REQ;
                  req_d   = 1'b1;
                  wen_d   = 1'b1;
                  add_d   = {base_idx_s, 2'b00};
               end else begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end
         RD_REQ: begin
            abort_d = abort_any_s;
            // A grant wins over abort: once the read is accepted its write-back must follow.
            if (tcdm_gnt_i) begin
               req_d   = 1'b0;
               state_d = RD_WAIT;
            end else if (abort_any_s) begin
               req_d   = 1'b0;
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
         RD_WAIT: begin
            abort_d = abort_any_s;
            if (tcdm_r_valid_i) begin
               if (resp_err_s) begin
                  err_d   = 1'b1;
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  wdata_d = {tag_q, tcdm_r_rdata_i[31:0]};
                  req_d   = 1'b1;
                  wen_d   = 1'b0;
                  state_d = WR_REQ;
               end
            end
         end
         WR_REQ: begin
            abort_d = abort_any_s;
            if (tcdm_gnt_i) begin
               req_d   = 1'b0;
               state_d = WR_WAIT;
            end
         end
         WR_WAIT: begin
            abort_d = abort_any_s;
            if (tcdm_r_valid_i) begin
               cur_d = nxt_idx_s;
               if (resp_err_s) begin
                  err_d   = 1'b1;
                  state_d = DONE;
                  done_d  = 1'b1;
               end else if ((nxt_idx_s >= end_q) || abort_any_s) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = RD_REQ;
                  req_d   = 1'b1;
                  wen_d   = 1'b1;
                  add_d   = {nxt_idx_s, 2'b00};
               end
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            req_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cur_q   <= '0;
         end_q   <= '0;
         tag_q   <= '0;
         abort_q <= 1'b0;
         req_q   <= 1'b0;
         wen_q   <= 1'b1;
         add_q   <= '0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         end_q   <= end_d;
         tag_q   <= tag_d;
         abort_q <= abort_d;
         req_q   <= req_d;
         wen_q   <= wen_d;
         add_q   <= add_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign tcdm_req_o   = req_q;
   assign tcdm_add_o   = add_q;
   assign tcdm_wen_o   = wen_q;
   assign tcdm_be_o    = 4'hF;
   assign tcdm_wdata_o = wdata_q;

endmodule

// File: tb/tb_dift_tag_init_engine.sv
// Directed bench for dift_tag_init_engine with a TCDM memory model and a transaction scoreboard.
module tb_dift_tag_init_engine;
   import pkg_dift::*;

   localparam logic [31:0] MEM_BASE = 32'h1C00_0000;

   logic        clk = 1'b0;
   logic        rst_i, start_i, abort_i;
   logic [31:0] base_addr_i, end_addr_i;
   logic [3:0]  tag_val_i;
   logic        busy_o, done_o, err_o;
   logic        tcdm_req_o, tcdm_wen_o;
   logic [31:0] tcdm_add_o;
   logic [3:0]  tcdm_be_o;
   logic [35:0] tcdm_wdata_o;
   logic        gnt_tb = 1'b0, rvalid_tb = 1'b0, opc_tb = 1'b0;
   logic [35:0] rdata_tb = 36'h0;

   always #5 clk = ~clk;

   dift_tag_init_engine dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
      .base_addr_i(base_addr_i), .end_addr_i(end_addr_i), .tag_val_i(tag_val_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .tcdm_req_o(tcdm_req_o), .tcdm_add_o(tcdm_add_o), .tcdm_wen_o(tcdm_wen_o),
      .tcdm_be_o(tcdm_be_o), .tcdm_wdata_o(tcdm_wdata_o),
      .tcdm_gnt_i(gnt_tb), .tcdm_r_valid_i(rvalid_tb),
      .tcdm_r_rdata_i(rdata_tb), .tcdm_r_opc_i(opc_tb)
   );

   typedef struct packed {
      logic        wen;
      logic [31:0] add;
      logic [35:0] wdata;
   } txn_t;

   int          checks = 0;
   int          errors = 0;
   int          txn_cnt = 0;
   int unsigned stall_max = 0;
   logic        hold_gnt = 1'b0;
   logic        inject_opc = 1'b0;
   int          opc_idx = -1;
   txn_t        exp_q[$];
   logic [35:0] mem [0:63];

   function automatic logic [35:0] init_word(input int i);
      if (i < 4) return {4'h0, 32'hA5A5_A5A5};
      return {4'hA, 32'h5A5A_0000 ^ (i * 32'h0101_0101)};
   endfunction

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pushes the read/write pairs for n words, plus an optional lone read of the following word.
   task automatic push_words(input int idx, input int n, input logic [3:0] tag, input bit tail_read);
      logic [31:0] a;
      for (int i = 0; i < n + (tail_read ? 1 : 0); i++) begin
         a = MEM_BASE + 32'((idx + i) * 4);
         exp_q.push_back('{wen: 1'b1, add: a, wdata: 36'h0});
         if (i < n) exp_q.push_back('{wen: 1'b0, add: a, wdata: {tag, init_word(idx + i)[31:0]}});
      end
   endtask

   task automatic start_op(input int idx, input int n, input logic [3:0] tag);
      base_addr_i = MEM_BASE + 32'(idx * 4);
      end_addr_i  = MEM_BASE + 32'((idx + n) * 4);
      tag_val_i   = tag;
      start_i     = 1'b1;
      @(posedge clk); #1;
      start_i     = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (done_o !== 1'b1 && n < budget);
      chk("done_seen", {71'h0, done_o}, 72'h1);
   endtask

   task automatic check_word(input string tag, input int i, input logic [35:0] exp);
      chk(tag, {36'h0, mem[i]}, {36'h0, exp});
   endtask

   // TCDM slave: grants after a random stall, answers one cycle after each grant.
   logic        stalling = 1'b0;
   int unsigned stall_cnt = 0;
   logic [68:0] snap;
   txn_t        cap;
   logic        mem_ready = 1'b0;
   always @(negedge clk) begin
      txn_t obs;
      int   idx;
      if (!mem_ready) begin
         for (int i = 0; i < 64; i++) mem[i] = init_word(i);
         mem_ready = 1'b1;
      end
      rvalid_tb = 1'b0;
      opc_tb    = 1'b0;
      if (gnt_tb) begin
         obs = '{wen: cap.wen, add: cap.add, wdata: (cap.wen ? 36'h0 : cap.wdata)};
         chk("be", {68'h0, tcdm_be_o}, {68'h0, 4'hF});
         chk("sb_pending", {71'h0, (exp_q.size() != 0)}, 72'h1);
         if (exp_q.size() != 0) chk("txn", {3'h0, obs}, {3'h0, exp_q.pop_front()});
         idx = int'((cap.add - MEM_BASE) >> 2);
         if (idx < 64) begin
            if (cap.wen) begin
               rdata_tb = mem[idx];
               opc_tb   = inject_opc && (idx == opc_idx);
            end else begin
               mem[idx] = cap.wdata;
               rdata_tb = 36'h0;
            end
         end
         rvalid_tb = 1'b1;
         txn_cnt++;
      end
      gnt_tb = 1'b0;
      if (tcdm_req_o && !hold_gnt) begin
         if (!stalling) begin
            stalling  = 1'b1;
            stall_cnt = $urandom_range(stall_max);
            snap      = {tcdm_wen_o, tcdm_add_o, tcdm_wdata_o};
         end else begin
            chk("stall_stable", {3'h0, tcdm_wen_o, tcdm_add_o, tcdm_wdata_o}, {3'h0, snap});
         end
         if (stall_cnt == 0) begin
            gnt_tb   = 1'b1;
            stalling = 1'b0;
            cap      = '{wen: tcdm_wen_o, add: tcdm_add_o, wdata: tcdm_wdata_o};
         end else begin
            stall_cnt--;
         end
      end else begin
         stalling = 1'b0;
      end
   end

   initial begin
      int n;
      int t0;
      rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
      base_addr_i = 32'h0; end_addr_i = 32'h0; tag_val_i = 4'h0;
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      @(posedge clk); #1;
      chk("rst_req",   {71'h0, tcdm_req_o}, 72'h0);
      chk("rst_wen",   {71'h0, tcdm_wen_o}, 72'h1);
      chk("rst_add",   {40'h0, tcdm_add_o}, 72'h0);
      chk("rst_wdata", {36'h0, tcdm_wdata_o}, 72'h0);
      chk("rst_flags", {69'h0, busy_o, done_o, err_o}, 72'h0);

      // Four words, zero-wait: 4 cycles per word.
      t0 = txn_cnt;
      push_words(0, 4, TAG_ALL_TAINTED, 1'b0);
      start_op(0, 4, TAG_ALL_TAINTED);
      chk("t1_busy", {71'h0, busy_o}, 72'h1);
      wait_done(100, n);
      chk("t1_cycles", 72'(n), 72'd16);
      chk("t1_txns", 72'(txn_cnt - t0), 72'd8);
      for (int i = 0; i < 4; i++) check_word("t1_mem", i, {4'hF, 32'hA5A5_A5A5});
      check_word("t1_mem_next", 4, init_word(4));
      @(posedge clk); #1;
      chk("t1_after", {70'h0, busy_o, done_o}, 72'h0);
      chk("t1_sb_empty", 72'(exp_q.size()), 72'd0);

      // Empty range: straight to DONE, no bus traffic.
      t0 = txn_cnt;
      base_addr_i = 32'h1C00_0100; end_addr_i = 32'h1C00_0100; tag_val_i = 4'hF;
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      chk("t2_busy_done", {70'h0, busy_o, done_o}, 72'h3);
      chk("t2_req", {71'h0, tcdm_req_o}, 72'h0);
      @(posedge clk); #1;
      chk("t2_after", {70'h0, busy_o, done_o}, 72'h0);
      repeat (3) @(posedge clk);
      #1 chk("t2_txns", 72'(txn_cnt - t0), 72'd0);

      // Random grant stalls over eight words.
      stall_max = 5;
      t0 = txn_cnt;
      push_words(16, 8, 4'h6, 1'b0);
      start_op(16, 8, 4'h6);
      wait_done(1000, n);
      chk("t3_txns", 72'(txn_cnt - t0), 72'd16);
      for (int i = 16; i < 24; i++) check_word("t3_mem", i, {4'h6, init_word(i)[31:0]});
      check_word("t3_mem_next", 24, init_word(24));
      chk("t3_sb_empty", 72'(exp_q.size()), 72'd0);
      stall_max = 0;
      @(posedge clk); #1;

      // Abort during the read of word 2: word 2 still written back, word 3 untouched.
      push_words(32, 3, TAG_ALL_CLEAN, 1'b0);
      start_op(32, 4, TAG_ALL_CLEAN);
      repeat (9) @(posedge clk);
      #1 abort_i = 1'b1;
      @(posedge clk); #1 abort_i = 1'b0;
      wait_done(100, n);
      for (int i = 32; i < 35; i++) check_word("t4_mem", i, {4'h0, init_word(i)[31:0]});
      check_word("t4_word3", 35, init_word(35));
      chk("t4_sb_empty", 72'(exp_q.size()), 72'd0);
      @(posedge clk); #1;
      chk("t4_busy_fell", {71'h0, busy_o}, 72'h0);

      // Reset while in WR_REQ of the first word.
      push_words(48, 0, 4'h3, 1'b1);
      start_op(48, 2, 4'h3);
      repeat (2) @(posedge clk);
      #1 chk("t5_in_wr_req", {70'h0, tcdm_req_o, tcdm_wen_o}, 72'h2);
      hold_gnt = 1'b1;
      rst_i    = 1'b1;
      @(posedge clk); #1;
      chk("t5_req", {71'h0, tcdm_req_o}, 72'h0);
      chk("t5_wen_add", {39'h0, tcdm_wen_o, tcdm_add_o}, {39'h0, 1'b1, 32'h0});
      chk("t5_wdata", {36'h0, tcdm_wdata_o}, 72'h0);
      chk("t5_flags", {69'h0, busy_o, done_o, err_o}, 72'h0);
      rst_i = 1'b0; hold_gnt = 1'b0;
      chk("t5_sb_empty", 72'(exp_q.size()), 72'd0);
      check_word("t5_word_kept", 48, init_word(48));
      push_words(48, 1, 4'h3, 1'b0);
      start_op(48, 1, 4'h3);
      wait_done(100, n);
      chk("t5_restart_cycles", 72'(n), 72'd4);
      check_word("t5_mem", 48, {4'h3, init_word(48)[31:0]});
      check_word("t5_mem_next", 49, init_word(49));
      @(posedge clk); #1;

      // Response error on the read of word 57.
      inject_opc = 1'b1;
      opc_idx    = 57;
`ifdef DIFT_TAG_INIT_ERR_EN
      push_words(56, 1, 4'h5, 1'b1);
      start_op(56, 3, 4'h5);
      wait_done(100, n);
      chk("t6_err", {71'h0, err_o}, 72'h1);
      check_word("t6_mem56", 56, {4'h5, init_word(56)[31:0]});
      check_word("t6_mem57", 57, init_word(57));
      check_word("t6_mem58", 58, init_word(58));
      chk("t6_sb_empty", 72'(exp_q.size()), 72'd0);
      @(posedge clk); #1;
      chk("t6_err_sticky", {71'h0, err_o}, 72'h1);
      inject_opc = 1'b0;
      push_words(58, 1, 4'h5, 1'b0);
      start_op(58, 1, 4'h5);
      chk("t6_err_cleared", {71'h0, err_o}, 72'h0);
      wait_done(100, n);
      check_word("t6_mem58_after", 58, {4'h5, init_word(58)[31:0]});
`else
      push_words(56, 3, 4'h5, 1'b0);
      start_op(56, 3, 4'h5);
      wait_done(100, n);
      chk("t6_err_ignored", {71'h0, err_o}, 72'h0);
      for (int i = 56; i < 59; i++) check_word("t6_mem", i, {4'h5, init_word(i)[31:0]});
      chk("t6_sb_empty", 72'(exp_q.size()), 72'd0);
`endif
      inject_opc = 1'b0;
      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
